// File: rtl/rv_core_pkg.sv
// -----------------------------------------------------------------------------
// rv_core_pkg
// Shared types and constants for the fetch stage:
//   fetch_state_e : fetch FSM states (IDLE/REQ/WAIT/DRAIN)
//   NOP_INSTR     : word substituted for a faulting fetch (addi x0,x0,0)
//   FAULT_*       : fault codes carried with each fetched entry
//   fetch_entry_t : one fetch buffer entry {instr, pc, fault}
// -----------------------------------------------------------------------------
package rv_core_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_WAIT  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS      = 2'b10;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fault;
    } fetch_entry_t;

    function automatic logic pc_aligned(input logic [1:0] pc_lsb);
        return pc_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch entries with a registered head and a flush input.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : empty the FIFO at the next edge; writes that cycle dropped
//   i_wr_en/i_wr_data : push an entry
//   i_rd_en        : pop the head (ignored when empty)
//   o_rd_data      : head entry (storage register, no bypass from i_wr_data)
//   o_valid        : FIFO not empty
//   o_count        : number of stored entries
// -----------------------------------------------------------------------------
module fetch_fifo
    import rv_core_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  fetch_entry_t               i_wr_data,
    input  logic                       i_rd_en,
    output fetch_entry_t               o_rd_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_ok, rd_ok;

    // A write into a full FIFO is legal when the head leaves in the same cycle.
    assign rd_ok = i_rd_en && (count_q != '0);
    assign wr_ok = i_wr_en && ((count_q != DEPTH_C) || rd_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + AW'(1);
            if (rd_ok) rptr_d = rptr_q + AW'(1);
            if (wr_ok && !rd_ok)      count_d = count_q + CW'(1);
            else if (!wr_ok && rd_ok) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok && !i_flush) mem_q[wptr_q] <= i_wr_data;
    end

    assign o_rd_data = mem_q[rptr_q];
    assign o_valid   = (count_q != '0);
    assign o_count   = count_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage between the PC register and decode. One memory read per PC value,
// at most one transaction outstanding, results buffered with their PC in a
// fetch FIFO and handed to decode over valid/ready.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_boot_hold      : start address being loaded, no fetch issued
//   i_pc             : current PC
//   i_flush          : redirect, discard everything in flight
//   o_pc_stall       : PC must hold (low for exactly one cycle per accepted fetch)
//   o_imem_req/addr  : read request, held until i_imem_gnt
//   i_imem_rvalid/rdata/err : read response (err qualified by rvalid)
//   o_instr_valid/o_instr/o_instr_pc/o_instr_fault : entry to decode
//   i_dec_ready      : decode accepts the entry
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = rv_core_pkg::NOP_INSTR
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_boot_hold,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_pc_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic [1:0]  o_instr_fault,
    input  logic        i_dec_ready
);

    import rv_core_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_lat_q, pc_lat_d;

    logic          fifo_wr, fifo_rd, fifo_valid;
    fetch_entry_t  wr_entry, head;
    logic [CW-1:0] fifo_count;

    logic          req, granted, mis_push;

    always_comb begin
        state_d  = state_q;
        pc_lat_d = pc_lat_q;
        req      = 1'b0;
        granted  = 1'b0;
        mis_push = 1'b0;
        fifo_wr  = 1'b0;
        wr_entry = '0;

        unique case (state_q)
            // No transaction is outstanding in IDLE, so the FIFO count is the whole credit.
            FS_IDLE: begin
                if (!i_boot_hold && !i_flush && (fifo_count < DEPTH_C)) begin
                    if (pc_aligned(i_pc[1:0])) begin
                        state_d = FS_REQ;
                    end else begin
                        fifo_wr  = 1'b1;
                        mis_push = 1'b1;
                        wr_entry = '{instr: NOP_INSTR, pc: i_pc, fault: FAULT_MISALIGN};
                    end
                end
            end

            // Boot hold withdraws a pending request so the PC is never advanced
            // while it is being loaded.
            FS_REQ: begin
                if (i_boot_hold && !i_flush) begin
                    state_d = FS_IDLE;
                end else begin
                    req = 1'b1;
                    if (i_imem_gnt) begin
                        granted  = 1'b1;
                        pc_lat_d = i_pc;
                        state_d  = i_flush ? FS_DRAIN : FS_WAIT;
                    end else if (i_flush) begin
                        state_d = FS_IDLE;
                    end
                end
            end

            // Chaining straight into REQ ignores a same-cycle pop, which only
            // ever delays a fetch and never overcommits the FIFO.
            FS_WAIT: begin
                if (i_imem_rvalid) begin
                    if (!i_flush) begin
                        fifo_wr  = 1'b1;
                        wr_entry = '{instr: i_imem_rdata, pc: pc_lat_q,
                                     fault: i_imem_err ? FAULT_BUS : FAULT_NONE};
                    end
                    if (!i_flush && !i_boot_hold && pc_aligned(i_pc[1:0]) &&
                        ((fifo_count + CW'(1)) < DEPTH_C))
                        state_d = FS_REQ;
                    else
                        state_d = FS_IDLE;
                end else if (i_flush) begin
                    state_d = FS_DRAIN;
                end
            end

            FS_DRAIN: begin
                if (i_imem_rvalid) state_d = FS_IDLE;
            end

            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= FS_IDLE;
            pc_lat_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_lat_q <= pc_lat_d;
        end
    end

    // Flush releases the PC so it loads the branch target.
    always_comb begin
        if (i_flush)          o_pc_stall = 1'b0;
        else if (i_boot_hold) o_pc_stall = 1'b1;
        else                  o_pc_stall = !(granted || mis_push);
    end

    assign o_imem_req  = req;
    assign o_imem_addr = req ? i_pc : '0;

    assign fifo_rd = fifo_valid && i_dec_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_flush   (i_flush),
        .i_wr_en   (fifo_wr),
        .i_wr_data (wr_entry),
        .i_rd_en   (fifo_rd),
        .o_rd_data (head),
        .o_valid   (fifo_valid),
        .o_count   (fifo_count)
    );

    // Outputs read zero whenever nothing is presented, matching the reset state.
    assign o_instr_valid = fifo_valid;
    assign o_instr       = fifo_valid ? head.instr : '0;
    assign o_instr_pc    = fifo_valid ? head.pc    : '0;
    assign o_instr_fault = fifo_valid ? head.fault : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch. The PC register and instruction memory are modelled
// here; every PC value the PC register steps past (without a redirect) must
// come out to decode, in order, with its memory word or fault. A redirect
// cancels everything not yet consumed.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst_n, i_boot_hold, i_flush, i_imem_gnt, i_imem_rvalid, i_imem_err, i_dec_ready;
    logic [31:0] i_pc, i_imem_rdata;
    logic        o_pc_stall, o_imem_req, o_instr_valid;
    logic [31:0] o_imem_addr, o_instr, o_instr_pc;
    logic [1:0]  o_instr_fault;

    always #5 clk = ~clk;

    instr_fetch #(
        .FIFO_DEPTH (DEPTH),
        .NOP_INSTR  (NOP)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (i_rst_n),
        .i_boot_hold   (i_boot_hold),
        .i_pc          (i_pc),
        .i_flush       (i_flush),
        .o_pc_stall    (o_pc_stall),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_imem_err    (i_imem_err),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_instr_pc    (o_instr_pc),
        .o_instr_fault (o_instr_fault),
        .i_dec_ready   (i_dec_ready)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } pend_t;

    exp_t  expq[$];
    pend_t pendq[$];

    int unsigned n_cmp = 0, n_err = 0;
    int unsigned iter = 0, grants = 0, stall_lows = 0, pops = 0;
    int          first_valid = -1;
    logic [31:0] pc_model = '0;
    logic [31:0] last_pop_pc = '1, last_grant_addr = '1, force_target = '0;
    logic [1:0]  last_pop_fault = '0;
    logic        force_flush = 1'b0;
    logic        last_valid, last_req, last_stall;
    logic [31:0] last_instr, last_instr_pc;
    logic [1:0]  last_fault;

    int unsigned gnt_pct = 100, ready_pct = 100, flush_pct = 0, stray_pct = 0;
    int unsigned dmin = 1, dmax = 1;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0)  return 32'h0050_0093;
        if (a == 32'h80) return 32'hDEAD_BEEF;
        return (a * 32'h0100_0193) ^ 32'h1234_5678;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[6:2] == 5'h10;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = {22'b0, 8'($urandom), 2'b00};
        if (($urandom % 8) == 0) t[1:0] = 2'($urandom_range(3, 1));
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (iter %0d)", name, got, exp, iter);
        end
    endtask

    // Scoreboard monitor: compares every entry decode accepts against the
    // oldest outstanding expectation, and checks the head holds while stalled.
    initial begin : monitor
        exp_t        e;
        logic        hold_prev;
        logic [31:0] p_instr, p_pc;
        logic [1:0]  p_fault;
        hold_prev = 1'b0;
        p_instr = '0; p_pc = '0; p_fault = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!i_rst_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("hold_valid", 32'(o_instr_valid), 32'd1);
                    check("hold_instr", o_instr, p_instr);
                    check("hold_pc", o_instr_pc, p_pc);
                    check("hold_fault", 32'(o_instr_fault), 32'(p_fault));
                end
                if (o_instr_valid && i_dec_ready) begin
                    pops++;
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_entry: got pc %h instr %h, expected no entry", o_instr_pc, o_instr);
                    end else begin
                        e = expq.pop_front();
                        check("entry_instr", o_instr, e.instr);
                        check("entry_pc", o_instr_pc, e.pc);
                        check("entry_fault", 32'(o_instr_fault), 32'(e.fault));
                    end
                    last_pop_pc    = o_instr_pc;
                    last_pop_fault = o_instr_fault;
                end
                hold_prev = o_instr_valid && !i_dec_ready && !i_flush;
                p_instr = o_instr; p_pc = o_instr_pc; p_fault = o_instr_fault;
            end
        end
    end

    // One clock cycle of PC register + memory + decode behaviour. Called at a
    // falling edge; returns at the next falling edge.
    task automatic step();
        logic [31:0] tgt;
        logic        flush_now;
        pend_t       p;
        exp_t        e;
        i_pc      = pc_model;
        flush_now = 1'b0;
        tgt       = '0;
        if (force_flush) begin
            flush_now   = 1'b1;
            tgt         = force_target;
            force_flush = 1'b0;
        end else if (($urandom % 100) < flush_pct) begin
            flush_now = 1'b1;
            tgt       = rand_target();
        end
        i_flush       = flush_now;
        i_dec_ready   = ($urandom % 100) < ready_pct;
        i_imem_rvalid = 1'b0;
        i_imem_err    = 1'b0;
        i_imem_rdata  = $urandom;
        if (pendq.size() != 0) begin
            if (pendq[0].due <= iter) begin
                p             = pendq.pop_front();
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = mem_data(p.addr);
                i_imem_err    = mem_err(p.addr);
            end
        end else if (($urandom % 100) < stray_pct) begin
            i_imem_rvalid = 1'b1;
            i_imem_err    = 1'($urandom);
        end
        i_imem_gnt = 1'b0;
        #1;
        i_imem_gnt = o_imem_req && (($urandom % 100) < gnt_pct);
        #2;

        if (o_imem_req) check("imem_addr", o_imem_addr, pc_model);
        if (pc_model[1:0] != 2'b00) check("misaligned_no_req", 32'(o_imem_req), 32'd0);
        if (i_boot_hold && !flush_now) check("boot_hold_stall", 32'(o_pc_stall), 32'd1);
        if (flush_now) check("flush_stall", 32'(o_pc_stall), 32'd0);
        if (o_imem_req && i_imem_gnt) check("grant_stall", 32'(o_pc_stall), 32'd0);
        if (!o_pc_stall && !flush_now)
            check("stall_cause", 32'((o_imem_req && i_imem_gnt) ||
                                     (!o_imem_req && pc_model[1:0] != 2'b00)), 32'd1);

        last_valid    = o_instr_valid;
        last_req      = o_imem_req;
        last_stall    = o_pc_stall;
        last_instr    = o_instr;
        last_instr_pc = o_instr_pc;
        last_fault    = o_instr_fault;
        if (o_instr_valid && first_valid < 0) first_valid = int'(iter);

        if (o_imem_req && i_imem_gnt) begin
            grants++;
            last_grant_addr = o_imem_addr;
            p.addr = pc_model;
            p.due  = iter + $urandom_range(dmax, dmin);
            pendq.push_back(p);
        end
        if (!o_pc_stall) stall_lows++;

        if (flush_now) begin
            expq.delete();
            pc_model = tgt;
        end else if (!o_pc_stall) begin
            e.pc = pc_model;
            if (pc_model[1:0] != 2'b00) begin
                e.instr = NOP;
                e.fault = 2'b01;
            end else begin
                e.instr = mem_data(pc_model);
                e.fault = mem_err(pc_model) ? 2'b10 : 2'b00;
            end
            expq.push_back(e);
            pc_model = pc_model + 32'd4;
        end
        check("credit_bound", 32'(expq.size() <= DEPTH), 32'd1);

        iter++;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic hold);
        i_rst_n       = 1'b0;
        i_boot_hold   = hold;
        i_flush       = 1'b0;
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_err    = 1'b0;
        i_dec_ready   = 1'b0;
        expq.delete();
        pendq.delete();
        pc_model = '0;
        i_pc     = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(o_imem_req), 32'd0);
        check("rst_valid", 32'(o_instr_valid), 32'd0);
        check("rst_instr", o_instr, 32'd0);
        check("rst_instr_pc", o_instr_pc, 32'd0);
        check("rst_fault", 32'(o_instr_fault), 32'd0);
        check("rst_stall", 32'(o_pc_stall), 32'd1);
        @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          base, g0, s0;
        i_imem_rdata = '0;
        i_pc         = '0;

        // Reset release, immediate grant, one-cycle memory latency.
        gnt_pct = 100; ready_pct = 100; flush_pct = 0; stray_pct = 0; dmin = 1; dmax = 1;
        do_reset(1'b0);
        base = int'(iter); g0 = int'(grants); s0 = int'(stall_lows); first_valid = -1;
        repeat (8) step();
        check("t1_first_valid_cycle", 32'(first_valid - base), 32'd3);
        check("t1_stall_per_grant", 32'(int'(stall_lows) - s0), 32'(int'(grants) - g0));

        // Decode blocked: the FIFO fills and the third request is withheld.
        ready_pct = 0;
        do_reset(1'b0);
        g0 = int'(grants);
        repeat (12) step();
        check("t2_two_grants", 32'(int'(grants) - g0), 32'd2);
        check("t2_req_withheld", 32'(last_req), 32'd0);
        check("t2_pc_stalled", 32'(last_stall), 32'd1);
        ready_pct = 100;
        step();
        ready_pct = 0;
        for (int i = 0; i < 10 && (int'(grants) - g0) < 3; i++) step();
        check("t2_third_grant", 32'(int'(grants) - g0), 32'd3);

        // Redirect while a fetch is in flight: its word is dropped.
        ready_pct = 100; dmin = 3; dmax = 3;
        force_flush = 1'b1; force_target = 32'h80;
        step();
        last_grant_addr = '1;
        for (int i = 0; i < 15 && last_grant_addr != 32'h80; i++) step();
        check("t3_grant_0x80", last_grant_addr, 32'h80);
        force_flush = 1'b1; force_target = 32'h100;
        step();
        step();
        check("t3_fifo_empty", 32'(last_valid), 32'd0);
        last_pop_pc = '1;
        for (int i = 0; i < 20 && last_pop_pc != 32'h100; i++) step();
        check("t3_target_delivered", last_pop_pc, 32'h100);

        // Misaligned PC: fault entry without a memory request.
        dmin = 1; dmax = 1;
        force_flush = 1'b1; force_target = 32'h102;
        step();
        last_pop_pc = '1;
        for (int i = 0; i < 20 && last_pop_pc != 32'h102; i++) step();
        check("t4_misaligned_pc", last_pop_pc, 32'h102);
        check("t4_misaligned_fault", 32'(last_pop_fault), 32'd1);

        // Bus error.
        force_flush = 1'b1; force_target = 32'h40;
        step();
        last_pop_pc = '1;
        for (int i = 0; i < 20 && last_pop_pc != 32'h40; i++) step();
        check("t5_bus_err_pc", last_pop_pc, 32'h40);
        check("t5_bus_err_fault", 32'(last_pop_fault), 32'd2);

        // Reset in the middle of a transaction; the late response must be ignored.
        dmin = 6; dmax = 6;
        force_flush = 1'b1; force_target = 32'h300;
        step();
        last_grant_addr = '1;
        for (int i = 0; i < 15 && last_grant_addr != 32'h300; i++) step();
        check("t6_grant_0x300", last_grant_addr, 32'h300);
        do_reset(1'b1);
        stray_pct = 100;
        repeat (4) step();
        check("t6_valid", 32'(last_valid), 32'd0);
        check("t6_req", 32'(last_req), 32'd0);
        check("t6_instr", last_instr, 32'd0);
        check("t6_instr_pc", last_instr_pc, 32'd0);
        check("t6_fault", 32'(last_fault), 32'd0);
        check("t6_stall", 32'(last_stall), 32'd1);

        // Randomised traffic.
        for (int seg = 0; seg < 20; seg++) begin
            gnt_pct   = $urandom_range(100, 30);
            ready_pct = $urandom_range(100, 20);
            flush_pct = $urandom_range(8, 0);
            stray_pct = $urandom_range(20, 0);
            dmin      = 1;
            dmax      = $urandom_range(4, 1);
            i_boot_hold = (($urandom % 10) == 0);
            repeat (200) step();
        end

        // Drain whatever is still buffered or in flight.
        i_boot_hold = 1'b1;
        gnt_pct = 100; ready_pct = 100; flush_pct = 0; stray_pct = 0;
        for (int i = 0; i < 50 && (expq.size() != 0 || pendq.size() != 0 || last_valid); i++) step();
        check("final_scoreboard_empty", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
